usb_tx_phy: RTL and testbench
=============================

# usb_tx_phy

Transmit-side USB full-speed line encoder for the USB UART stack. It takes packet bytes from the protocol layer over a valid/ready/last byte handshake and produces the ECP5 bidirectional pin drive signals `usb_p_tx`, `usb_n_tx` and `usb_tx_en`. For each packet it generates SYNC, the LSB-first data bits with bit stuffing and NRZI encoding, and EOP, all at 12 Mbit/s from the 48 MHz clock. It feeds the tristate pin wrapper, which forces the receive path to J while `usb_tx_en` is high.

## Interface
- `CLK_DIV`, default 4: clocks per USB bit period. Must be ≥2.
- `clk_48mhz`  input  1  system clock, 48 MHz.
- `reset_n`  input  1  reset, synchronous, active-low.
- `tx_data`  input  8  packet byte, sent LSB first.
- `tx_valid`  input  1  `tx_data`/`tx_last` are valid. It is held for the whole packet.
- `tx_last`  input  1  the accepted byte is the final byte of the packet.
- `tx_ready`  output  1  one-cycle accept strobe. A byte transfers when `tx_valid && tx_ready`.
- `tx_err`  output  1  one-cycle pulse on underrun.
- `busy`  output  1  high from the start of SYNC through the end of EOP.
- `usb_p_tx`  output  1  D+ drive value.
- `usb_n_tx`  output  1  D− drive value.
- `usb_tx_en`  output  1  output enable for the pin drivers.

## Operation
- **State machine.** States are IDLE, SYNC, DATA, EOP.
- **Line states.** J is p=1,n=0. K is p=0,n=1. SE0 is p=0,n=0. All pin outputs are registered.
- **Bit timer.** Counter `bt` runs 0..CLK_DIV−1. It is cleared on leaving IDLE. The cycle with bt==CLK_DIV−1 is the *boundary*; the next bit appears on the outputs the following cycle.
- **IDLE.** Outputs are J, `usb_tx_en`=0, `busy`=0. When `tx_valid`=1, go to SYNC. No byte is accepted in this cycle.
- **SYNC.** Sends the bit pattern 0x80 LSB-first: seven 0s, then a 1.
- **NRZI encoding.** A 0 bit toggles J↔K. A 1 bit holds the current state. The line is J before the first SYNC bit, so SYNC comes out as KJKJKJKK.
- **Byte load.** On the boundary of SYNC bit 7, and on the boundary of bit 7 of every non-last byte, `tx_ready`=1 for that one cycle.
  - If `tx_valid`=1, load `tx_data` into the shifter and latch `tx_last`. The state is (or stays) DATA.
  - If `tx_valid`=0, this is an underrun. Pulse `tx_err` in the same cycle and go to EOP. If this happens at the end of SYNC, the packet is SYNC+EOP only.
- **Bit stuffing.**
  - A ones counter counts consecutive 1 bits, including the final SYNC 1.
  - Any 0 bit, including a stuffed 0, clears it.
  - When the count reaches 6, the next bit period sends a stuffed 0 (a toggle) before the next data bit. This holds across byte boundaries, and after the last byte before EOP.
  - Stuffed bits do not move the byte-load point; the load happens on the boundary of data bit 7.
- **End of last byte.** After bit 7 of the byte latched with `tx_last` (and any pending stuffed bit), go to EOP.
- **EOP.** Sends SE0 for 2 bit periods, then J for 1 bit period with `usb_tx_en`=1. Then return to IDLE: `usb_tx_en`=0, output J.
- **IDLE re-entry.** A new packet may start on the cycle after returning to IDLE.
- **Widths.** `bt` is $clog2(CLK_DIV) bits. The ones counter is 3 bits, saturating is not needed. The bit counter is 3 bits and wraps 7→0.

## Timing
- **Reset values.** Every cycle with `reset_n`=0 gives, on the next edge: `usb_p_tx`=1, `usb_n_tx`=0, `usb_tx_en`=0, `tx_ready`=0, `tx_err`=0, `busy`=0, state IDLE, all counters 0.
- **Reset mid-packet.** Same result. The packet is abandoned with no EOP.
- **Start of packet.** If `tx_valid` is first seen in IDLE at cycle T:
  - `usb_tx_en`=1, `busy`=1 and the first SYNC K appear at T+1.
  - Bit i occupies cycles T+1+i·CLK_DIV through T+(i+1)·CLK_DIV.
- **First accept.** With CLK_DIV=4 this is at cycle T+32. Later accepts follow at each +32 cycles plus 4 cycles per stuffed bit in between.
- **Packet length.** `usb_tx_en` stays high for CLK_DIV·(8 + 8N + S + 3) cycles, where N is the byte count and S the number of stuffed bits.
- **Handshake.** `tx_ready` does not depend combinationally on `tx_valid`. `tx_err` and `tx_ready` are never high together with an accepted byte.

## Test plan
- **Reset.** Hold `reset_n`=0 for 3 cycles → p=1, n=0, `usb_tx_en`=0, `busy`=0, `tx_ready`=0.
- **Single byte 0x00, `tx_last`=1.**
  - Line sequence per bit is KJKJKJKK JKJKJKJK SE0 SE0 J.
  - `tx_ready` pulses once, at T+32.
  - `usb_tx_en` is high for exactly 76 cycles.
- **Single byte 0xFF, last.**
  - After SYNC the line holds K for 5 bits, then a stuffed J, then J for 3 bits, then SE0 SE0 J.
  - `usb_tx_en` is high for 80 cycles.
- **Single byte 0xFC, last.**
  - Data is 0,0 then six 1s. A stuffed toggle follows the final 1, before the SE0s.
  - `usb_tx_en` is high for 80 cycles.
- **Two bytes 0xA5 then 0x3C (last), back-to-back.**
  - `tx_ready` pulses at T+32 and T+64.
  - Decoded NRZI bits equal 0xA5, 0x3C LSB-first.
  - `usb_tx_en` is high for 108 cycles.
- **Underrun.**
  - Send 0x55 without `tx_last`, then drop `tx_valid`.
  - `tx_err` pulses at T+64, then EOP follows and `usb_tx_en` falls at T+76.
- **Reset mid-packet.** Apply reset during DATA → outputs return to J with `usb_tx_en`=0 at the next edge.
- **Back-to-back packets.** Start a new packet right after IDLE is reached → it starts cleanly.

Source files
------------

// File: rtl/usb_tx_phy.sv
// -----------------------------------------------------------------------------
// usb_tx_phy
//   USB full-speed transmit line encoder. Takes packet bytes over a
//   valid/ready/last handshake and drives the D+/D- pins with SYNC, NRZI
//   encoded bit-stuffed data (LSB first) and EOP at one bit per CLK_DIV clocks.
//
// Parameters
//   CLK_DIV    clocks per USB bit period (must be >= 2)
//
// Ports
//   clk_48mhz  in   system clock
//   reset_n    in   synchronous active-low reset
//   tx_data    in   packet byte, sent LSB first
//   tx_valid   in   tx_data/tx_last valid, held for the whole packet
//   tx_last    in   accepted byte is the final byte of the packet
//   tx_ready   out  one-cycle accept strobe (byte moves on tx_valid && tx_ready)
//   tx_err     out  one-cycle underrun pulse
//   busy       out  high from start of SYNC to end of EOP
//   usb_p_tx   out  D+ drive value (registered)
//   usb_n_tx   out  D- drive value (registered)
//   usb_tx_en  out  pin driver output enable (registered)
// -----------------------------------------------------------------------------
module usb_tx_phy #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk_48mhz,
  input  logic       reset_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic       tx_err,
  output logic       busy,
  output logic       usb_p_tx,
  output logic       usb_n_tx,
  output logic       usb_tx_en
);

  localparam int             BT_W    = $clog2(CLK_DIV);
  localparam logic [BT_W-1:0] BT_LAST = BT_W'(CLK_DIV - 1);
  localparam logic [BT_W-1:0] BT_ONE  = BT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SYNC,
    ST_DATA,
    ST_EOP
  } state_t;

  // Registered state
  state_t          r_state;
  logic [BT_W-1:0] r_bt;
  logic [2:0]      r_bitcnt;    // SYNC bit / last data bit sent / EOP period
  logic [2:0]      r_ones;      // consecutive ones ending with the bit on the line
  logic            r_stuff;     // bit currently on the line is a stuffed 0
  logic            r_eop_pend;  // stuffed bit closes the last byte, EOP follows
  logic [7:0]      r_byte;
  logic            r_last;
  logic            r_p;
  logic            r_n;
  logic            r_en;
  logic            r_busy;

  // Next-state / decode
  state_t          w_state_nxt;
  logic [2:0]      w_bitcnt_nxt;
  logic [2:0]      w_ones_nxt;
  logic            w_stuff_nxt;
  logic            w_eop_pend_nxt;
  logic            w_p_nxt;
  logic            w_n_nxt;
  logic            w_en_nxt;
  logic            w_busy_nxt;
  logic            w_boundary;
  logic            w_ready;
  logic            w_load;
  logic            w_emit;      // put a new NRZI bit on the line at this edge
  logic            w_bit;       // value of that bit before NRZI
  logic [2:0]      w_idx;
  logic            w_fin;
  logic            w_eop_go;

  assign w_boundary = (r_bt == BT_LAST);

  always_comb begin
    w_state_nxt    = r_state;
    w_bitcnt_nxt   = r_bitcnt;
    w_ones_nxt     = r_ones;
    w_stuff_nxt    = r_stuff;
    w_eop_pend_nxt = r_eop_pend;
    w_p_nxt        = r_p;
    w_n_nxt        = r_n;
    w_en_nxt       = r_en;
    w_busy_nxt     = r_busy;
    w_ready        = 1'b0;
    w_load         = 1'b0;
    w_emit         = 1'b0;
    w_bit          = 1'b0;
    w_idx          = r_bitcnt + 3'd1;
    w_fin          = 1'b0;
    w_eop_go       = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        w_p_nxt        = 1'b1;
        w_n_nxt        = 1'b0;
        w_en_nxt       = 1'b0;
        w_busy_nxt     = 1'b0;
        w_ones_nxt     = 3'd0;
        w_stuff_nxt    = 1'b0;
        w_eop_pend_nxt = 1'b0;
        w_bitcnt_nxt   = 3'd0;
        if (tx_valid) begin
          // First SYNC bit (a 0) goes out on the next edge: J -> K.
          w_state_nxt = ST_SYNC;
          w_en_nxt    = 1'b1;
          w_busy_nxt  = 1'b1;
          w_emit      = 1'b1;
          w_bit       = 1'b0;
        end
      end

      ST_SYNC: begin
        if (w_boundary) begin
          if (r_bitcnt != 3'd7) begin
            w_emit       = 1'b1;
            w_bit        = (r_bitcnt == 3'd6);
            w_bitcnt_nxt = w_idx;
          end else begin
            w_ready = 1'b1;
            if (tx_valid) begin
              // SYNC ends with a single 1, so no stuff can be due here.
              w_load       = 1'b1;
              w_state_nxt  = ST_DATA;
              w_emit       = 1'b1;
              w_bit        = tx_data[0];
              w_bitcnt_nxt = 3'd0;
            end else begin
              w_eop_go = 1'b1;
            end
          end
        end
      end

      ST_DATA: begin
        if (w_boundary) begin
          w_fin = r_stuff ? r_eop_pend : ((r_bitcnt == 3'd7) && r_last);
          // Byte load is tied to data bit 7, never to a stuffed bit.
          if (!r_stuff && (r_bitcnt == 3'd7) && !r_last) begin
            w_ready = 1'b1;
            if (tx_valid) begin
              w_load = 1'b1;
            end else begin
              w_eop_go = 1'b1;
            end
          end
          if (!w_eop_go) begin
            if (!r_stuff && (r_ones == 3'd6)) begin
              w_emit         = 1'b1;
              w_bit          = 1'b0;
              w_stuff_nxt    = 1'b1;
              w_eop_pend_nxt = w_fin;
            end else if (w_fin) begin
              w_eop_go = 1'b1;
            end else begin
              // After bit 7 the index wraps to 0; a byte loaded this cycle
              // is not in r_byte yet, so take its bit 0 straight from the port.
              w_emit       = 1'b1;
              w_bit        = w_load ? tx_data[0] : r_byte[w_idx];
              w_stuff_nxt  = 1'b0;
              w_bitcnt_nxt = w_idx;
            end
          end
        end
      end

      ST_EOP: begin
        // Periods 0 and 1 are SE0, period 2 is J, then release the bus.
        if (w_boundary) begin
          if (r_bitcnt == 3'd2) begin
            w_state_nxt  = ST_IDLE;
            w_bitcnt_nxt = 3'd0;
            w_p_nxt      = 1'b1;
            w_n_nxt      = 1'b0;
            w_en_nxt     = 1'b0;
            w_busy_nxt   = 1'b0;
          end else begin
            w_bitcnt_nxt = w_idx;
            if (r_bitcnt == 3'd1) begin
              w_p_nxt = 1'b1;
              w_n_nxt = 1'b0;
            end
          end
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    if (w_eop_go) begin
      w_state_nxt    = ST_EOP;
      w_bitcnt_nxt   = 3'd0;
      w_stuff_nxt    = 1'b0;
      w_eop_pend_nxt = 1'b0;
      w_p_nxt        = 1'b0;
      w_n_nxt        = 1'b0;
    end

    // NRZI: a 0 toggles J/K, a 1 holds the line.
    if (w_emit) begin
      if (!w_bit) begin
        w_p_nxt = ~r_p;
        w_n_nxt = ~r_n;
      end
      w_ones_nxt = w_bit ? (r_ones + 3'd1) : 3'd0;
    end
  end

  always_ff @(posedge clk_48mhz) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_bt       <= '0;
      r_bitcnt   <= 3'd0;
      r_ones     <= 3'd0;
      r_stuff    <= 1'b0;
      r_eop_pend <= 1'b0;
      r_last     <= 1'b0;
      r_p        <= 1'b1;
      r_n        <= 1'b0;
      r_en       <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_bitcnt   <= w_bitcnt_nxt;
      r_ones     <= w_ones_nxt;
      r_stuff    <= w_stuff_nxt;
      r_eop_pend <= w_eop_pend_nxt;
      r_p        <= w_p_nxt;
      r_n        <= w_n_nxt;
      r_en       <= w_en_nxt;
      r_busy     <= w_busy_nxt;
      if ((r_state == ST_IDLE) || w_boundary) begin
        r_bt <= '0;
      end else begin
        r_bt <= r_bt + BT_ONE;
      end
      if (w_load) begin
        r_last <= tx_last;
      end
    end
  end

  // Byte shifter holds data only; it is always loaded before use.
  always_ff @(posedge clk_48mhz) begin
    if (w_load) begin
      r_byte <= tx_data;
    end
  end

  assign tx_ready  = w_ready;
  assign tx_err    = w_ready && !tx_valid;
  assign busy      = r_busy;
  assign usb_p_tx  = r_p;
  assign usb_n_tx  = r_n;
  assign usb_tx_en = r_en;

endmodule

// File: tb/tb_usb_tx_phy.sv
module tb_usb_tx_phy;

  localparam int MAXC = 200;

  logic       clk_48mhz = 1'b0;
  logic       reset_n;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_last;
  logic       tx_ready;
  logic       tx_err;
  logic       busy;
  logic       usb_p_tx;
  logic       usb_n_tx;
  logic       usb_tx_en;

  int total = 0;
  int bad   = 0;

  logic [1:0] cap_line  [0:MAXC];
  logic       cap_ready [0:MAXC];
  logic       cap_err   [0:MAXC];
  logic       cap_busy  [0:MAXC];
  int         cap_len;

  always #5 clk_48mhz = ~clk_48mhz;

  usb_tx_phy #(.CLK_DIV(4)) dut (
    .clk_48mhz (clk_48mhz),
    .reset_n   (reset_n),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_last   (tx_last),
    .tx_ready  (tx_ready),
    .tx_err    (tx_err),
    .busy      (busy),
    .usb_p_tx  (usb_p_tx),
    .usb_n_tx  (usb_n_tx),
    .usb_tx_en (usb_tx_en)
  );

  function automatic byte lc(input logic [1:0] pn);
    case (pn)
      2'b10:   lc = "J";
      2'b01:   lc = "K";
      2'b00:   lc = "0";
      default: lc = "?";
    endcase
  endfunction

  // Starts a packet in the current cycle (T) and records every cycle T+k
  // until usb_tx_en drops. Returns at the negedge of the first idle cycle.
  task automatic send_pkt(input int nb, input logic [7:0] b0, input logic [7:0] b1,
                          input bit under);
    int bi;
    bit acc;
    for (int k = 0; k <= MAXC; k++) begin
      cap_line[k] = 2'b11; cap_ready[k] = 1'b0; cap_err[k] = 1'b0; cap_busy[k] = 1'b0;
    end
    cap_len  = -1;
    bi       = 0;
    tx_valid = 1'b1;
    tx_data  = b0;
    tx_last  = (nb == 1) && !under;
    @(posedge clk_48mhz);
    if (nb == 0) begin
      #1;
      tx_valid = 1'b0;
    end
    for (int k = 1; k <= MAXC; k++) begin
      @(negedge clk_48mhz);
      cap_line[k]  = {usb_p_tx, usb_n_tx};
      cap_ready[k] = tx_ready;
      cap_err[k]   = tx_err;
      cap_busy[k]  = busy;
      if (usb_tx_en !== 1'b1) begin
        cap_len = k - 1;
        break;
      end
      acc = (tx_ready === 1'b1) && tx_valid;
      @(posedge clk_48mhz);
      #1;
      if (acc) begin
        bi++;
        if (bi < nb) begin
          tx_data = b1;
          tx_last = (bi == nb - 1) && !under;
        end else begin
          tx_valid = 1'b0;
        end
      end
    end
    tx_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset_n  = 1'b0;
    tx_valid = 1'b0;
    tx_last  = 1'b0;
    tx_data  = 8'h00;
    repeat (3) @(posedge clk_48mhz);
    @(negedge clk_48mhz);
    total++; if (usb_p_tx !== 1'b1)  begin bad++; $display("FAIL reset_p got=%b want=1", usb_p_tx); end
    total++; if (usb_n_tx !== 1'b0)  begin bad++; $display("FAIL reset_n got=%b want=0", usb_n_tx); end
    total++; if (usb_tx_en !== 1'b0) begin bad++; $display("FAIL reset_en got=%b want=0", usb_tx_en); end
    total++; if (busy !== 1'b0)      begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (tx_ready !== 1'b0)  begin bad++; $display("FAIL reset_ready got=%b want=0", tx_ready); end
    total++; if (tx_err !== 1'b0)    begin bad++; $display("FAIL reset_err got=%b want=0", tx_err); end
    reset_n = 1'b1;
    @(negedge clk_48mhz);
    total++;
    if ({usb_p_tx, usb_n_tx, usb_tx_en} !== 3'b100) begin
      bad++; $display("FAIL reset_idle got=%b want=100", {usb_p_tx, usb_n_tx, usb_tx_en});
    end
  endtask

  task automatic test_byte00();
    string exp;
    exp = "KJKJKJKKJKJKJKJK00J";
    send_pkt(1, 8'h00, 8'h00, 1'b0);
    total++; if (cap_len != 76) begin bad++; $display("FAIL b00_len got=%0d want=76", cap_len); end
    for (int k = 1; k <= 76; k++) begin
      total++;
      if (lc(cap_line[k]) != exp[(k-1)/4]) begin
        bad++; $display("FAIL b00_line cyc=%0d got=%c want=%c", k, lc(cap_line[k]), exp[(k-1)/4]);
      end
      total++;
      if (cap_ready[k] !== (k == 32)) begin
        bad++; $display("FAIL b00_ready cyc=%0d got=%b want=%b", k, cap_ready[k], (k == 32));
      end
      total++;
      if (cap_err[k] !== 1'b0) begin bad++; $display("FAIL b00_err cyc=%0d got=%b want=0", k, cap_err[k]); end
      total++;
      if (cap_busy[k] !== 1'b1) begin bad++; $display("FAIL b00_busy cyc=%0d got=%b want=1", k, cap_busy[k]); end
    end
  endtask

  task automatic test_stuff_ff();
    string exp;
    exp = "KJKJKJKKKKKKKJJJJ00J";
    send_pkt(1, 8'hFF, 8'h00, 1'b0);
    total++; if (cap_len != 80) begin bad++; $display("FAIL bff_len got=%0d want=80", cap_len); end
    for (int k = 1; k <= 80; k++) begin
      total++;
      if (lc(cap_line[k]) != exp[(k-1)/4]) begin
        bad++; $display("FAIL bff_line cyc=%0d got=%c want=%c", k, lc(cap_line[k]), exp[(k-1)/4]);
      end
      total++;
      if (cap_ready[k] !== (k == 32)) begin
        bad++; $display("FAIL bff_ready cyc=%0d got=%b want=%b", k, cap_ready[k], (k == 32));
      end
    end
  endtask

  task automatic test_stuff_fc();
    string exp;
    exp = "KJKJKJKKJKKKKKKKJ00J";
    send_pkt(1, 8'hFC, 8'h00, 1'b0);
    total++; if (cap_len != 80) begin bad++; $display("FAIL bfc_len got=%0d want=80", cap_len); end
    for (int k = 1; k <= 80; k++) begin
      total++;
      if (lc(cap_line[k]) != exp[(k-1)/4]) begin
        bad++; $display("FAIL bfc_line cyc=%0d got=%c want=%c", k, lc(cap_line[k]), exp[(k-1)/4]);
      end
    end
  endtask

  task automatic test_two_bytes();
    string exp;
    logic [15:0] want;
    logic dec;
    exp  = "KJKJKJKKKJJKJJKKJKKKKKJK00J";
    want = 16'h3CA5;
    send_pkt(2, 8'hA5, 8'h3C, 1'b0);
    total++; if (cap_len != 108) begin bad++; $display("FAIL two_len got=%0d want=108", cap_len); end
    for (int k = 1; k <= 108; k++) begin
      total++;
      if (lc(cap_line[k]) != exp[(k-1)/4]) begin
        bad++; $display("FAIL two_line cyc=%0d got=%c want=%c", k, lc(cap_line[k]), exp[(k-1)/4]);
      end
      total++;
      if (cap_ready[k] !== ((k == 32) || (k == 64))) begin
        bad++; $display("FAIL two_ready cyc=%0d got=%b want=%b", k, cap_ready[k], ((k == 32) || (k == 64)));
      end
    end
    for (int i = 8; i < 24; i++) begin
      dec = (cap_line[4*i + 2] === cap_line[4*(i-1) + 2]);
      total++;
      if (dec !== want[i-8]) begin
        bad++; $display("FAIL two_decode bit=%0d got=%b want=%b", i - 8, dec, want[i-8]);
      end
    end
  endtask

  task automatic test_underrun();
    string exp;
    exp = "KJKJKJKKKJJKKJJK00J";
    send_pkt(1, 8'h55, 8'h00, 1'b1);
    total++; if (cap_len != 76) begin bad++; $display("FAIL under_len got=%0d want=76", cap_len); end
    for (int k = 1; k <= 76; k++) begin
      total++;
      if (lc(cap_line[k]) != exp[(k-1)/4]) begin
        bad++; $display("FAIL under_line cyc=%0d got=%c want=%c", k, lc(cap_line[k]), exp[(k-1)/4]);
      end
      total++;
      if (cap_err[k] !== (k == 64)) begin
        bad++; $display("FAIL under_err cyc=%0d got=%b want=%b", k, cap_err[k], (k == 64));
      end
      total++;
      if (cap_ready[k] !== ((k == 32) || (k == 64))) begin
        bad++; $display("FAIL under_ready cyc=%0d got=%b want=%b", k, cap_ready[k], ((k == 32) || (k == 64)));
      end
    end
  endtask

  task automatic test_sync_underrun();
    string exp;
    exp = "KJKJKJKK00J";
    send_pkt(0, 8'h00, 8'h00, 1'b0);
    total++; if (cap_len != 44) begin bad++; $display("FAIL sync_under_len got=%0d want=44", cap_len); end
    for (int k = 1; k <= 44; k++) begin
      total++;
      if (lc(cap_line[k]) != exp[(k-1)/4]) begin
        bad++; $display("FAIL sync_under_line cyc=%0d got=%c want=%c", k, lc(cap_line[k]), exp[(k-1)/4]);
      end
      total++;
      if (cap_err[k] !== (k == 32)) begin
        bad++; $display("FAIL sync_under_err cyc=%0d got=%b want=%b", k, cap_err[k], (k == 32));
      end
    end
  endtask

  task automatic test_reset_mid();
    tx_valid = 1'b1;
    tx_data  = 8'h00;
    tx_last  = 1'b1;
    repeat (40) @(posedge clk_48mhz);
    @(negedge clk_48mhz);
    total++; if (usb_tx_en !== 1'b1) begin bad++; $display("FAIL mid_active_en got=%b want=1", usb_tx_en); end
    reset_n  = 1'b0;
    tx_valid = 1'b0;
    @(negedge clk_48mhz);
    total++;
    if ({usb_p_tx, usb_n_tx} !== 2'b10) begin
      bad++; $display("FAIL mid_line got=%b want=10", {usb_p_tx, usb_n_tx});
    end
    total++; if (usb_tx_en !== 1'b0) begin bad++; $display("FAIL mid_en got=%b want=0", usb_tx_en); end
    total++; if (busy !== 1'b0)      begin bad++; $display("FAIL mid_busy got=%b want=0", busy); end
    reset_n = 1'b1;
    repeat (3) @(negedge clk_48mhz);
    total++; if (usb_tx_en !== 1'b0) begin bad++; $display("FAIL mid_after_en got=%b want=0", usb_tx_en); end
  endtask

  task automatic test_back_to_back();
    string exp;
    exp = "KJKJKJKKKKKKJKJK00J";
    send_pkt(1, 8'h00, 8'h00, 1'b0);
    total++; if (cap_len != 76) begin bad++; $display("FAIL b2b_first_len got=%0d want=76", cap_len); end
    send_pkt(1, 8'h0F, 8'h00, 1'b0);
    total++; if (cap_len != 76) begin bad++; $display("FAIL b2b_second_len got=%0d want=76", cap_len); end
    for (int k = 1; k <= 76; k++) begin
      total++;
      if (lc(cap_line[k]) != exp[(k-1)/4]) begin
        bad++; $display("FAIL b2b_line cyc=%0d got=%c want=%c", k, lc(cap_line[k]), exp[(k-1)/4]);
      end
      total++;
      if (cap_ready[k] !== (k == 32)) begin
        bad++; $display("FAIL b2b_ready cyc=%0d got=%b want=%b", k, cap_ready[k], (k == 32));
      end
    end
  endtask

  initial begin
    reset_n  = 1'b0;
    tx_valid = 1'b0;
    tx_last  = 1'b0;
    tx_data  = 8'h00;
    test_reset();
    test_byte00();
    test_stuff_ff();
    test_stuff_fc();
    test_two_bytes();
    test_underrun();
    test_sync_underrun();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
